// File: rtl/put_ring_ctrl.sv
// ---------------------------------------------------------------------------
// put_ring_ctrl
//   Put-side controller of the token-ring FIFO. Steers each accepted producer
//   word to the cell currently holding the put token, issues the one-shot
//   ring token init after reset, and tracks per-cell occupancy so it can
//   raise full / almost_full. Drained cells are reported by the get side on
//   cell_empty, which is already synchronised to clk_put.
//
// Ports
//   clk_put       in   put-domain clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   req_put       in   producer write request (data_put valid while high)
//   data_put      in   producer data word
//   cell_empty    in   per-cell empty level from the get side
//   tok_init      out  one-cycle pulse loading the ring's initial token
//   put_tok       out  one-hot put-token position
//   cell_we       out  one-hot registered write strobe to the cell array
//   cell_din      out  registered write data, valid with cell_we
//   put_ack       out  request accepted on the previous edge
//   full          out  token cell occupied, no accept possible
//   almost_full   out  occupancy at or above NCELLS-AF_MARGIN
//   overflow_err  out  sticky: req_put seen while full
// ---------------------------------------------------------------------------
module put_ring_ctrl #(
  parameter int WIDTH     = 8,
  parameter int NCELLS    = 4,
  parameter int AF_MARGIN = 1
) (
  input  logic              clk_put,
  input  logic              reset_n,
  input  logic              req_put,
  input  logic [WIDTH-1:0]  data_put,
  input  logic [NCELLS-1:0] cell_empty,
  output logic              tok_init,
  output logic [NCELLS-1:0] put_tok,
  output logic [NCELLS-1:0] cell_we,
  output logic [WIDTH-1:0]  cell_din,
  output logic              put_ack,
  output logic              full,
  output logic              almost_full,
  output logic              overflow_err
);

  localparam int CW = $clog2(NCELLS + 1);
  localparam logic [CW-1:0] AF_THRESH = CW'(NCELLS - AF_MARGIN);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            state_reg;
  logic [NCELLS-1:0] occ_reg;
  logic [NCELLS-1:0] empty_q_reg;

  logic              accept;
  logic [NCELLS-1:0] rise;
  logic [NCELLS-1:0] occ_next;
  logic [NCELLS-1:0] tok_next;
  logic [CW-1:0]     count_next;
  logic              full_next;
  logic              af_next;

  assign accept = (state_reg == S_RUN) && req_put && !full;

  // A drained cell shows up as a rising edge of its empty level.
  assign rise = cell_empty & ~empty_q_reg;

  // A write into a cell wins over a drain report for the same cell.
  for (genvar gi = 0; gi < NCELLS; gi++) begin : g_occ
    assign occ_next[gi] = (accept && put_tok[gi]) || (occ_reg[gi] && !rise[gi]);
  end

  assign tok_next = accept ? {put_tok[NCELLS-2:0], put_tok[NCELLS-1]} : put_tok;

  always_comb begin
    count_next = '0;
    for (int i = 0; i < NCELLS; i++) begin
      count_next = count_next + CW'(occ_next[i]);
    end
  end

  // Full looks ahead at the cell the token will sit on after this edge.
  assign full_next = |(occ_next & tok_next);
  assign af_next   = (count_next >= AF_THRESH);

  always_ff @(posedge clk_put or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_RST;
      occ_reg      <= '0;
      empty_q_reg  <= '1;
      put_tok      <= NCELLS'(1);
      cell_we      <= '0;
      cell_din     <= '0;
      put_ack      <= 1'b0;
      tok_init     <= 1'b0;
      full         <= 1'b1;
      almost_full  <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      case (state_reg)
        S_RST:   state_reg <= S_INIT;
        S_INIT:  state_reg <= S_RUN;
        default: state_reg <= S_RUN;
      endcase

      // Registered outputs track the state being entered on this edge.
      tok_init    <= (state_reg == S_RST);
      full        <= (state_reg == S_RST) ? 1'b1 : full_next;
      almost_full <= af_next;

      empty_q_reg <= cell_empty;
      occ_reg     <= occ_next;
      put_tok     <= tok_next;
      cell_we     <= accept ? put_tok : '0;
      put_ack     <= accept;
      if (accept) begin
        cell_din <= data_put;
      end

      if ((state_reg == S_RUN) && req_put && full) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_put_ring_ctrl.sv
// ---------------------------------------------------------------------------
// tb_put_ring_ctrl
//   Directed bench for put_ring_ctrl (WIDTH=8, NCELLS=4, AF_MARGIN=1).
//   The stimulus process pushes the expected {cell_we, cell_din} of every
//   write it issues into a queue; a separate monitor pops and compares each
//   time the DUT presents a write strobe. Flag checks are made directly by
//   the stimulus process on the falling edge.
// ---------------------------------------------------------------------------
module tb_put_ring_ctrl;

  localparam int WIDTH  = 8;
  localparam int NCELLS = 4;

  logic              clk_put;
  logic              reset_n;
  logic              req_put;
  logic [WIDTH-1:0]  data_put;
  logic [NCELLS-1:0] cell_empty;
  logic              tok_init;
  logic [NCELLS-1:0] put_tok;
  logic [NCELLS-1:0] cell_we;
  logic [WIDTH-1:0]  cell_din;
  logic              put_ack;
  logic              full;
  logic              almost_full;
  logic              overflow_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [NCELLS-1:0] we;
    logic [WIDTH-1:0]  din;
  } exp_t;

  exp_t exp_q[$];

  put_ring_ctrl #(.WIDTH(WIDTH), .NCELLS(NCELLS), .AF_MARGIN(1)) dut (
    .clk_put      (clk_put),
    .reset_n      (reset_n),
    .req_put      (req_put),
    .data_put     (data_put),
    .cell_empty   (cell_empty),
    .tok_init     (tok_init),
    .put_tok      (put_tok),
    .cell_we      (cell_we),
    .cell_din     (cell_din),
    .put_ack      (put_ack),
    .full         (full),
    .almost_full  (almost_full),
    .overflow_err (overflow_err)
  );

  initial begin
    clk_put = 1'b0;
    forever #5 clk_put = ~clk_put;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(negedge clk_put);
  endtask

  // Issue one write that is expected to be accepted into cell exp_we.
  task automatic put_word(input logic [WIDTH-1:0] d, input logic [NCELLS-1:0] exp_we);
    exp_t e;
    req_put  = 1'b1;
    data_put = d;
    e.we  = exp_we;
    e.din = d;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic check_flags(input string tag, input logic f, input logic af,
                             input logic [NCELLS-1:0] tok);
    check({tag, " full"},        32'(full),        32'(f));
    check({tag, " almost_full"}, 32'(almost_full), 32'(af));
    check({tag, " put_tok"},     32'(put_tok),     32'(tok));
  endtask

  // Release reset on a falling edge and follow the S_RST/S_INIT/S_RUN ramp.
  task automatic release_and_init(input string tag);
    reset_n = 1'b1;
    check({tag, " tok_init cycle1"}, 32'(tok_init), 32'd0);
    tick();
    check({tag, " tok_init cycle2"}, 32'(tok_init), 32'd1);
    check({tag, " full cycle2"},     32'(full),     32'd1);
    tick();
    check({tag, " tok_init cycle3"}, 32'(tok_init), 32'd0);
    check_flags({tag, " cycle3"}, 1'b0, 1'b0, 4'b0001);
  endtask

  // Monitor: every presented write strobe must match the next queued entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_put);
      if (reset_n && (put_ack || cell_we != '0)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: cell_we=%b cell_din=0x%0h put_ack=%b, none expected",
                   cell_we, cell_din, put_ack);
        end else begin
          e = exp_q.pop_front();
          check("mon put_ack",  32'(put_ack),  32'd1);
          check("mon cell_we",  32'(cell_we),  32'(e.we));
          check("mon cell_din", 32'(cell_din), 32'(e.din));
        end
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    req_put    = 1'b0;
    data_put   = '0;
    cell_empty = '1;

    // Reset values
    repeat (2) tick();
    check("rst put_tok",      32'(put_tok),      32'h1);
    check("rst full",         32'(full),         32'd1);
    check("rst almost_full",  32'(almost_full),  32'd0);
    check("rst cell_we",      32'(cell_we),      32'd0);
    check("rst put_ack",      32'(put_ack),      32'd0);
    check("rst overflow_err", 32'(overflow_err), 32'd0);

    // Test 1: init sequence
    release_and_init("t1");

    // Test 2: four back-to-back writes fill the ring and wrap the token
    put_word(8'hA1, 4'b0001); check_flags("t2 w1", 1'b0, 1'b0, 4'b0010);
    put_word(8'hA2, 4'b0010); check_flags("t2 w2", 1'b0, 1'b0, 4'b0100);
    put_word(8'hA3, 4'b0100); check_flags("t2 w3", 1'b0, 1'b1, 4'b1000);
    put_word(8'hA4, 4'b1000); check_flags("t2 w4", 1'b1, 1'b1, 4'b0001);
    req_put = 1'b0;

    // Test 3: requests while full are dropped and flag overflow
    req_put  = 1'b1;
    data_put = 8'h55;
    tick();
    check("t3 overflow c1", 32'(overflow_err), 32'd1);
    check("t3 put_ack c1",  32'(put_ack),      32'd0);
    tick();
    check("t3 cell_we c2",  32'(cell_we),      32'd0);
    req_put = 1'b0;
    tick();
    check("t3 overflow held", 32'(overflow_err), 32'd1);
    check_flags("t3", 1'b1, 1'b1, 4'b0001);

    // Test 4: drain cell 0, then refill it
    cell_empty = 4'b1110;
    tick();
    check("t4 full after drop", 32'(full), 32'd1);
    cell_empty = 4'b1111;
    tick();
    check_flags("t4 after rise", 1'b0, 1'b1, 4'b0001);
    put_word(8'h77, 4'b0001);
    req_put = 1'b0;
    check_flags("t4 after write", 1'b1, 1'b1, 4'b0010);

    // Test 5: write cell 1 on the same edge cell 2 drains
    cell_empty = 4'b1001;
    tick();
    cell_empty = 4'b1011;
    tick();
    check_flags("t5 cell1 drained", 1'b0, 1'b1, 4'b0010);
    cell_empty = 4'b1111;
    put_word(8'h5A, 4'b0010);
    check_flags("t5 write+drain", 1'b0, 1'b1, 4'b0100);
    put_word(8'h6B, 4'b0100);
    req_put = 1'b0;
    check_flags("t5 refill cell2", 1'b1, 1'b1, 4'b1000);

    // Test 6: reset mid-burst
    reset_n = 1'b0;
    tick();
    release_and_init("t6a");
    put_word(8'hB1, 4'b0001);
    put_word(8'hB2, 4'b0010);
    data_put = 8'hB3;
    #2 reset_n = 1'b0;
    #1;
    check("t6 async put_tok",     32'(put_tok),      32'h1);
    check("t6 async cell_we",     32'(cell_we),      32'd0);
    check("t6 async cell_din",    32'(cell_din),     32'd0);
    check("t6 async put_ack",     32'(put_ack),      32'd0);
    check("t6 async full",        32'(full),         32'd1);
    check("t6 async almost_full", 32'(almost_full),  32'd0);
    req_put = 1'b0;
    tick();
    tick();
    release_and_init("t6b");
    put_word(8'hC1, 4'b0001);
    req_put = 1'b0;
    check_flags("t6 first write", 1'b0, 1'b0, 4'b0010);
    check("t6 overflow cleared", 32'(overflow_err), 32'd0);

    repeat (2) tick();
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
